// File: rtl/legv8_ctrl_pkg.sv
// Shared encodings for the LEGv8 multi-cycle controller: FSM states, opcode
// patterns, instruction classes, ALU control codes and fault codes.
package legv8_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_HALT   = 3'd6
    } state_t;

    typedef enum logic [2:0] {
        CLS_R    = 3'd0,
        CLS_LDUR = 3'd1,
        CLS_STUR = 3'd2,
        CLS_CBZ  = 3'd3,
        CLS_B    = 3'd4,
        CLS_ILL  = 3'd5
    } opClass_t;

    typedef enum logic [1:0] {
        FAULT_NONE    = 2'b00,
        FAULT_ILLEGAL = 2'b01,
        FAULT_TIMEOUT = 2'b10
    } fault_t;

    localparam logic [10:0] OP_ADD  = 11'b10001011000;
    localparam logic [10:0] OP_SUB  = 11'b11001011000;
    localparam logic [10:0] OP_AND  = 11'b10001010000;
    localparam logic [10:0] OP_ORR  = 11'b10101010000;
    localparam logic [10:0] OP_LDUR = 11'b11111000010;
    localparam logic [10:0] OP_STUR = 11'b11111000000;

    // CBZ and B carry immediate bits in the low opcode field, so they match on a prefix.
    localparam logic [10:0] CBZ_MASK  = 11'b11111111000;
    localparam logic [10:0] CBZ_MATCH = 11'b10110100000;
    localparam logic [10:0] B_MASK    = 11'b11111100000;
    localparam logic [10:0] B_MATCH   = 11'b00010100000;

    localparam logic [3:0] ALU_AND   = 4'b0000;
    localparam logic [3:0] ALU_ORR   = 4'b0001;
    localparam logic [3:0] ALU_ADD   = 4'b0010;
    localparam logic [3:0] ALU_SUB   = 4'b0110;
    localparam logic [3:0] ALU_PASSB = 4'b0111;

    function automatic logic matchMasked(input logic [10:0] op,
                                         input logic [10:0] mask,
                                         input logic [10:0] pattern);
        return (op & mask) == pattern;
    endfunction

endpackage

// File: rtl/multicycle_decode.sv
// Combinational opcode classifier: maps IR[31:21] to an instruction class and
// the ALU control code the EXEC state will drive for it.
module multicycle_decode
    import legv8_ctrl_pkg::*;
(
    input  logic [10:0] i_opcode,
    output opClass_t    o_opClass,
    output logic [3:0]  o_aluControl
);

    always_comb begin
        o_opClass    = CLS_ILL;
        o_aluControl = ALU_AND;
        if (i_opcode == OP_ADD) begin
            o_opClass    = CLS_R;
            o_aluControl = ALU_ADD;
        end else if (i_opcode == OP_SUB) begin
            o_opClass    = CLS_R;
            o_aluControl = ALU_SUB;
        end else if (i_opcode == OP_AND) begin
            o_opClass    = CLS_R;
            o_aluControl = ALU_AND;
        end else if (i_opcode == OP_ORR) begin
            o_opClass    = CLS_R;
            o_aluControl = ALU_ORR;
        end else if (i_opcode == OP_LDUR) begin
            o_opClass    = CLS_LDUR;
            o_aluControl = ALU_ADD;
        end else if (i_opcode == OP_STUR) begin
            o_opClass    = CLS_STUR;
            o_aluControl = ALU_ADD;
        end else if (matchMasked(i_opcode, CBZ_MASK, CBZ_MATCH)) begin
            o_opClass    = CLS_CBZ;
            o_aluControl = ALU_PASSB;
        end else if (matchMasked(i_opcode, B_MASK, B_MATCH)) begin
            o_opClass    = CLS_B;
            o_aluControl = ALU_AND;
        end
    end

endmodule

// File: rtl/multicycle_controller.sv
// LEGv8 multi-cycle sequencer: steps instructions through FETCH/DECODE/EXEC/MEM/WB,
// waits on the data cache with a timeout, and counts retired instructions.
module multicycle_controller
    import legv8_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             run,
    input  logic [10:0]      opcode,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             pc_src,
    output logic             ir_write,
    output logic             reg_write,
    output logic             reg2loc,
    output logic             alu_src,
    output logic             mem_to_reg,
    output logic [3:0]       alu_control,
    output logic             mem_read,
    output logic             mem_write,
    output logic             busy,
    output logic             halted,
    output logic [1:0]       fault,
    output logic [CNT_W-1:0] retired,
    output logic [2:0]       state
);

    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    state_t            r_state;
    state_t            w_nextState;
    opClass_t          r_opClass;
    logic [3:0]        r_aluControl;
    fault_t            r_fault;
    logic [CNT_W-1:0]  r_retired;
    logic [WAIT_W-1:0] r_waitCnt;
    opClass_t          w_decClass;
    logic [3:0]        w_decAlu;
    logic              w_memTimeout;

    multicycle_decode u_decode (
        .i_opcode     (opcode),
        .o_opClass    (w_decClass),
        .o_aluControl (w_decAlu)
    );

    // Timeout fires on the last permitted MEM cycle only if the cache is still not ready.
    assign w_memTimeout = (r_state == ST_MEM) && !mem_ready && (r_waitCnt == WAIT_LAST);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            ST_IDLE:   if (run) w_nextState = ST_FETCH;
            ST_FETCH:  w_nextState = run ? ST_DECODE : ST_IDLE;
            ST_DECODE: w_nextState = (w_decClass == CLS_ILL) ? ST_HALT : ST_EXEC;
            ST_EXEC: begin
                case (r_opClass)
                    CLS_R:              w_nextState = ST_WB;
                    CLS_LDUR, CLS_STUR: w_nextState = ST_MEM;
                    CLS_CBZ, CLS_B:     w_nextState = ST_FETCH;
                    default:            w_nextState = ST_HALT;
                endcase
            end
            ST_MEM: begin
                if (mem_ready) begin
                    w_nextState = (r_opClass == CLS_LDUR) ? ST_WB : ST_FETCH;
                end else if (w_memTimeout) begin
                    w_nextState = ST_HALT;
                end
            end
            ST_WB:     w_nextState = ST_FETCH;
            ST_HALT:   w_nextState = ST_HALT;
            default:   w_nextState = ST_IDLE;
        endcase
    end

    always_comb begin
        pc_write    = 1'b0;
        pc_src      = 1'b0;
        ir_write    = 1'b0;
        reg_write   = 1'b0;
        reg2loc     = 1'b0;
        alu_src     = 1'b0;
        mem_to_reg  = 1'b0;
        alu_control = ALU_AND;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        case (r_state)
            ST_FETCH: ir_write = run;
            ST_EXEC: begin
                alu_control = r_aluControl;
                case (r_opClass)
                    CLS_LDUR: alu_src = 1'b1;
                    CLS_STUR: begin
                        alu_src = 1'b1;
                        reg2loc = 1'b1;
                    end
                    CLS_CBZ: begin
                        reg2loc  = 1'b1;
                        pc_write = 1'b1;
                        pc_src   = zero;
                    end
                    CLS_B: begin
                        pc_write = 1'b1;
                        pc_src   = 1'b1;
                    end
                    default: ;
                endcase
            end
            ST_MEM: begin
                mem_read  = (r_opClass == CLS_LDUR);
                mem_write = (r_opClass == CLS_STUR);
                if (mem_ready && r_opClass == CLS_STUR) begin
                    pc_write = 1'b1;
                end
            end
            ST_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = (r_opClass == CLS_LDUR);
                pc_write   = 1'b1;
            end
            default: ;
        endcase
    end

    // Class is latched in DECODE so later states decode from a stable copy.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_opClass    <= CLS_R;
            r_aluControl <= ALU_AND;
            r_fault      <= FAULT_NONE;
            r_retired    <= '0;
            r_waitCnt    <= '0;
        end else begin
            if (r_state == ST_DECODE) begin
                r_opClass    <= w_decClass;
                r_aluControl <= w_decAlu;
                if (w_decClass == CLS_ILL) begin
                    r_fault <= FAULT_ILLEGAL;
                end
            end
            if (w_memTimeout) begin
                r_fault <= FAULT_TIMEOUT;
            end
            if (pc_write) begin
                r_retired <= r_retired + CNT_W'(1);
            end
            r_waitCnt <= (r_state == ST_MEM) ? r_waitCnt + WAIT_W'(1) : '0;
        end
    end

    assign busy    = (r_state != ST_IDLE) && (r_state != ST_HALT);
    assign halted  = (r_state == ST_HALT);
    assign fault   = r_fault;
    assign retired = r_retired;
    assign state   = r_state;

endmodule

// File: tb/tb_multicycle_controller.sv
// Randomized bench for multicycle_controller: each instruction is summarised by
// cycle count, strobe counts and EXEC controls, and compared with rule-derived values.
module tb_multicycle_controller;

    localparam int MEM_TIMEOUT = 16;
    localparam int CNT_W       = 4;

    localparam int K_ADD = 0, K_SUB = 1, K_AND = 2, K_ORR = 3, K_LDUR = 4,
                   K_STUR = 5, K_CBZ = 6, K_B = 7, K_ILL = 8;

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic             run = 1'b0;
    logic [10:0]      opcode = '0;
    logic             zero = 1'b0;
    logic             mem_ready = 1'b0;
    logic             pc_write, pc_src, ir_write, reg_write, reg2loc, alu_src;
    logic             mem_to_reg, mem_read, mem_write, busy, halted;
    logic [3:0]       alu_control;
    logic [1:0]       fault;
    logic [CNT_W-1:0] retired;
    logic [2:0]       state;

    int checks = 0;
    int failures = 0;
    int expRetired = 0;

    multicycle_controller #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
        .clock(clock), .reset(reset), .run(run), .opcode(opcode), .zero(zero),
        .mem_ready(mem_ready), .pc_write(pc_write), .pc_src(pc_src),
        .ir_write(ir_write), .reg_write(reg_write), .reg2loc(reg2loc),
        .alu_src(alu_src), .mem_to_reg(mem_to_reg), .alu_control(alu_control),
        .mem_read(mem_read), .mem_write(mem_write), .busy(busy), .halted(halted),
        .fault(fault), .retired(retired), .state(state)
    );

    always #5 clock = ~clock;

    initial begin
        #300000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    function automatic int classify(input logic [10:0] op);
        if (op == 11'b10001011000) return K_ADD;
        if (op == 11'b11001011000) return K_SUB;
        if (op == 11'b10001010000) return K_AND;
        if (op == 11'b10101010000) return K_ORR;
        if (op == 11'b11111000010) return K_LDUR;
        if (op == 11'b11111000000) return K_STUR;
        if (op[10:3] == 8'b10110100) return K_CBZ;
        if (op[10:5] == 6'b000101) return K_B;
        return K_ILL;
    endfunction

    function automatic logic [10:0] makeOpcode(input int kind);
        logic [10:0] op;
        case (kind)
            K_ADD:  op = 11'b10001011000;
            K_SUB:  op = 11'b11001011000;
            K_AND:  op = 11'b10001010000;
            K_ORR:  op = 11'b10101010000;
            K_LDUR: op = 11'b11111000010;
            K_STUR: op = 11'b11111000000;
            K_CBZ:  op = {8'b10110100, 3'($urandom)};
            K_B:    op = {6'b000101, 5'($urandom)};
            default: begin
                do op = 11'($urandom); while (classify(op) != K_ILL);
            end
        endcase
        return op;
    endfunction

    function automatic logic [3:0] expectedAlu(input int kind);
        case (kind)
            K_ADD, K_LDUR, K_STUR: return 4'b0010;
            K_SUB:                 return 4'b0110;
            K_AND:                 return 4'b0000;
            K_ORR:                 return 4'b0001;
            default:               return 4'b0111;
        endcase
    endfunction

    task automatic applyStimulus(input logic [10:0] op, input bit z, input int waits, input bit dropRun);
        int  kind = classify(op);
        bit  isMem = (kind == K_LDUR) || (kind == K_STUR);
        bit  expTimeout = isMem && (waits >= MEM_TIMEOUT);
        bit  expHalt = (kind == K_ILL) || expTimeout;
        int  expMem = !isMem ? 0 : (expTimeout ? MEM_TIMEOUT : waits + 1);
        int  expCycles;
        int  busyCnt = 0, irw = 0, rw = 0, m2r = 0, mr = 0, mw = 0, pcw = 0, memSeen = 0, haltPcw = 0;
        bit  found = 0, done = 0, haltKept = 1;
        logic       pcsAtWrite = 1'b0, srcEx = 1'b0, r2lEx = 1'b0;
        logic [3:0] aluEx = '0;

        case (kind)
            K_ADD, K_SUB, K_AND, K_ORR: expCycles = 4;
            K_LDUR:       expCycles = expTimeout ? 3 + expMem : 4 + expMem;
            K_STUR:       expCycles = 3 + expMem;
            K_CBZ, K_B:   expCycles = 3;
            default:      expCycles = 2;
        endcase

        opcode = op;
        zero   = z;
        run    = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (ir_write) begin
                found = 1;
                break;
            end
            @(negedge clock);
        end
        checkOutput("fetchSeen", 32'(found), 1);
        if (!found) return;

        for (int c = 0; c < 64 && !done; c++) begin
            if (c > 0) @(negedge clock);
            if (mem_read || mem_write) begin
                memSeen++;
                mem_ready = (memSeen > waits);
            end else begin
                mem_ready = 1'($urandom);
            end
            #1;
            if (halted) begin
                done = 1;
            end else begin
                if (busy) busyCnt++;
                irw += int'(ir_write);
                rw  += int'(reg_write);
                m2r += int'(mem_to_reg);
                mr  += int'(mem_read);
                mw  += int'(mem_write);
                pcw += int'(pc_write);
                if (busyCnt == 3) begin
                    aluEx = alu_control;
                    srcEx = alu_src;
                    r2lEx = reg2loc;
                end
                if (pc_write) begin
                    pcsAtWrite = pc_src;
                    done = 1;
                end
                if (busyCnt == 2 && dropRun) run = 1'b0;
            end
        end
        checkOutput("instrEnds", 32'(done), 1);
        checkOutput("cycles", busyCnt, expCycles);
        checkOutput("irWrite", irw, 1);
        checkOutput("regWrite", rw, (!expHalt && kind <= K_LDUR) ? 1 : 0);
        checkOutput("memToReg", m2r, (kind == K_LDUR && !expHalt) ? 1 : 0);
        checkOutput("memRead", mr, (kind == K_LDUR) ? expMem : 0);
        checkOutput("memWrite", mw, (kind == K_STUR) ? expMem : 0);
        checkOutput("pcWrite", pcw, expHalt ? 0 : 1);
        checkOutput("halted", 32'(halted), 32'(expHalt));
        checkOutput("fault", fault, (kind == K_ILL) ? 1 : (expTimeout ? 2 : 0));
        if (!expHalt)
            checkOutput("pcSrc", 32'(pcsAtWrite), (kind == K_CBZ) ? 32'(z) : ((kind == K_B) ? 1 : 0));
        if (kind != K_B && kind != K_ILL)
            checkOutput("aluExec", aluEx, expectedAlu(kind));
        if (kind <= K_STUR && kind != K_ILL)
            checkOutput("aluSrcExec", 32'(srcEx), (kind == K_LDUR || kind == K_STUR) ? 1 : 0);
        if (kind <= K_ORR || kind == K_STUR || kind == K_CBZ)
            checkOutput("reg2locExec", 32'(r2lEx), (kind == K_STUR || kind == K_CBZ) ? 1 : 0);

        if (!expHalt) expRetired = (expRetired + 1) % (1 << CNT_W);
        @(negedge clock);
        #1;
        checkOutput("retired", retired, expRetired);

        if (expHalt) begin
            run = 1'b1;
            for (int i = 0; i < 4; i++) begin
                @(negedge clock);
                #1;
                if (!halted) haltKept = 0;
                haltPcw += int'(pc_write);
            end
            checkOutput("haltStays", 32'(haltKept), 1);
            checkOutput("haltNoPcWrite", haltPcw, 0);
            reset = 1'b1;
            @(negedge clock);
            #1;
            checkOutput("resetState", state, 0);
            checkOutput("resetFault", fault, 0);
            checkOutput("resetRetired", retired, 0);
            checkOutput("resetHalted", 32'(halted), 0);
            reset = 1'b0;
            expRetired = 0;
        end else if (dropRun) begin
            checkOutput("fetchNoRun", 32'(ir_write), 0);
            @(negedge clock);
            #1;
            checkOutput("idleAfterDrop", 32'(busy), 0);
        end
    endtask

    task automatic resetInMem();
        bit found = 0;
        opcode    = 11'b11111000010;
        run       = 1'b1;
        mem_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clock);
            #1;
            if (mem_read) begin
                found = 1;
                break;
            end
        end
        checkOutput("memReached", 32'(found), 1);
        @(negedge clock);
        #1;
        checkOutput("memCycle2Read", 32'(mem_read), 1);
        reset = 1'b1;
        @(negedge clock);
        #1;
        checkOutput("midMemState", state, 0);
        checkOutput("midMemRead", 32'(mem_read), 0);
        checkOutput("midMemBusy", 32'(busy), 0);
        checkOutput("midMemRetired", retired, expRetired);
        reset = 1'b0;
    endtask

    initial begin
        int  kind, waits, pick;
        bit  z, drop;

        reset = 1'b1;
        run   = 1'b0;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        repeat (2) @(negedge clock);
        #1;
        checkOutput("resetStrobes",
                    {23'b0, pc_write, pc_src, ir_write, reg_write, reg2loc, alu_src, mem_to_reg, mem_read, mem_write}, 0);
        checkOutput("resetAlu", alu_control, 0);
        checkOutput("resetFault0", fault, 0);
        checkOutput("resetRetired0", retired, 0);
        checkOutput("resetBusy", 32'(busy), 0);
        checkOutput("resetHalted0", 32'(halted), 0);
        checkOutput("idleNoRun", state, 0);

        resetInMem();

        applyStimulus(makeOpcode(K_ADD), 1'b0, 0, 1'b0);
        applyStimulus(makeOpcode(K_LDUR), 1'b0, 3, 1'b0);
        applyStimulus(makeOpcode(K_STUR), 1'b0, 0, 1'b0);
        applyStimulus(makeOpcode(K_CBZ), 1'b1, 0, 1'b0);
        applyStimulus(makeOpcode(K_CBZ), 1'b0, 0, 1'b0);
        applyStimulus(makeOpcode(K_B), 1'b0, 0, 1'b1);
        applyStimulus(11'b11111111111, 1'b0, 0, 1'b0);
        applyStimulus(makeOpcode(K_LDUR), 1'b0, MEM_TIMEOUT, 1'b0);
        applyStimulus(makeOpcode(K_STUR), 1'b0, MEM_TIMEOUT - 1, 1'b0);

        for (int n = 0; n < 150; n++) begin
            pick = $urandom_range(0, 99);
            if (pick < 40)      kind = $urandom_range(K_ADD, K_ORR);
            else if (pick < 57) kind = K_LDUR;
            else if (pick < 70) kind = K_STUR;
            else if (pick < 84) kind = K_CBZ;
            else if (pick < 97) kind = K_B;
            else                kind = K_ILL;
            pick = $urandom_range(0, 19);
            if (pick < 13)       waits = $urandom_range(0, 3);
            else if (pick == 13) waits = MEM_TIMEOUT - 1;
            else if (pick == 14) waits = MEM_TIMEOUT;
            else if (pick < 17)  waits = 0;
            else                 waits = $urandom_range(4, 14);
            z    = 1'($urandom);
            drop = ($urandom_range(0, 7) == 0);
            applyStimulus(makeOpcode(kind), z, waits, drop);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Multi-cycle sequencing FSM for the LEGv8 datapath (PC unit, instruction memory, register file/operand prep, ALU, data cache). It replaces the single-cycle decoder/controller: it steps each instruction through FETCH/DECODE/EXEC/MEM/WB and drives per-state enables and strobes. It also waits on the data cache handshake with a timeout and counts retired instructions. It sits beside the datapath and takes only the latched opcode, the ALU zero flag and the cache ready signal.

## Interface
- MEM_TIMEOUT, 16, max cycles spent in MEM waiting for mem_ready before fault (≥1)
- CNT_W, 32, width of retired-instruction counter
- clock  in  1  single system clock, rising edge
- reset  in  1  synchronous, active-high
- run  in  1  level; enables fetching of new instructions
- opcode  in  11  IR[31:21] from the datapath instruction register
- zero  in  1  ALU zero flag (combinational from datapath)
- mem_ready  in  1  data cache access complete
- pc_write, pc_src  out  1 each  PC update enable; 0 = PC+4, 1 = PC+offset
- ir_write  out  1  latch instruction into IR
- reg_write, reg2loc, alu_src, mem_to_reg  out  1 each  datapath controls
- alu_control  out  4  0000 AND, 0001 ORR, 0010 ADD, 0110 SUB, 0111 pass-B
- mem_read, mem_write  out  1 each  data cache strobes
- busy  out  1  state ≠ IDLE and ≠ HALT
- halted  out  1  state = HALT
- fault  out  2  00 none, 01 illegal opcode, 10 memory timeout (sticky)
- retired  out  CNT_W  instructions completed
- state  out  3  current state encoding (debug)

## Operation
- Opcode classes: ADD 10001011000, SUB 11001011000, AND 10001010000, ORR 10101010000 (R); LDUR 11111000010; STUR 11111000000; CBZ opcode[10:3]=10110100; B opcode[10:5]=000101; anything else is illegal.
- IDLE: all strobes 0; run=1 -> FETCH.
- FETCH: if run=0 -> IDLE with no strobes; else ir_write=1 -> DECODE.
- DECODE: class and alu_control are registered from opcode. If illegal: fault=01 -> HALT. Otherwise -> EXEC.
- EXEC: alu_control is driven. R: reg2loc=0, alu_src=0 -> WB. LDUR/STUR: alu_src=1, ADD, reg2loc=1 for STUR -> MEM. CBZ: reg2loc=1, pass-B, pc_write=1, pc_src=zero -> FETCH, retire. B: pc_write=1, pc_src=1 -> FETCH, retire.
- MEM: mem_read (LDUR) or mem_write (STUR) is held high while waiting. On mem_ready=1, LDUR -> WB. On mem_ready=1, STUR does pc_write=1, pc_src=0 -> FETCH, retire. The wait counter clears on MEM entry. If mem_ready is still 0 after MEM_TIMEOUT cycles in MEM, strobes drop, fault=10 -> HALT.
- WB: reg_write=1, mem_to_reg=1 for LDUR only, pc_write=1, pc_src=0 -> FETCH, retire.
- HALT: all strobes 0; exits only on reset.
- retired increments by 1 on every pc_write cycle and wraps modulo 2^CNT_W.

## Timing
- Moore outputs decoded from state and registered class. The exception is pc_src in EXEC for CBZ, which follows zero combinationally.
- Cycles per instruction with zero wait states (mem_ready high on first MEM cycle): R 4, LDUR 5, STUR 4, CBZ/B 3. Each cycle of mem_ready low adds 1.
- Reset values: state IDLE, all strobes 0, alu_control 0000, fault 00, retired 0, busy 0, halted 0.
- Reset in any state, including mid-MEM, returns to IDLE at that edge. Strobes are 0 in the following cycle, and the partial instruction is not retired.
- reset dominates run. run is sampled only in IDLE and FETCH; dropping run mid-instruction completes that instruction first.
- mem_ready is ignored outside MEM.
- In MEM, mem_ready=1 on the final timeout cycle counts as success.

## Structure
- Package legv8_ctrl_pkg holds:
  - state encoding (IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT);
  - opcode constants and masks;
  - class enum (R, LDUR, STUR, CBZ, B, ILL);
  - alu_control codes;
  - fault codes.
- One sub-module, multicycle_decode: combinational opcode -> {class, alu_control}. It is instantiated in the controller and registered in DECODE.

## Test plan
- ADD opcode 10001011000, run=1 from reset: ir_write in cycle 1, DECODE, EXEC with alu_control=0010, WB with reg_write=1 and pc_write=1; retired=1 after 4 cycles.
- LDUR with mem_ready low 3 cycles: mem_read high 4 cycles, then WB with mem_to_reg=1; total 8 cycles; STUR with ready immediate gives mem_write 1 cycle, no reg_write, 4 cycles.
- CBZ with zero=1 gives pc_src=1 in EXEC; CBZ with zero=0 gives pc_src=0; B always pc_src=1; each takes 3 cycles and retired increments once.
- Opcode 11111111111: HALT after DECODE, fault=01, halted=1, no pc_write. It stays halted with run=1 until reset, then returns to IDLE with fault=00.
- LDUR with mem_ready stuck 0, MEM_TIMEOUT=16: mem_read high exactly 16 cycles, then fault=10 and HALT. Reset asserted in MEM cycle 2: IDLE next cycle, retired unchanged.
